// File: rtl/jtkcpu_pkg.sv
// ============================================================================
// jtkcpu_pkg : shared KCPU state encodings and operand widths  | rev 1.0
// ============================================================================
`default_nettype none

package jtkcpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD_HI = 2'd1;
  localparam logic [1:0] ST_RD_LO = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RD_HI = ST_RD_HI,
    RD_LO = ST_RD_LO,
    DONE  = ST_DONE
  } fetch_state_t;

  localparam int OPND_W8  = 8;
  localparam int OPND_W16 = 16;

endpackage

`default_nettype wire

// File: rtl/jtkcpu_opfetch.sv
// ============================================================================
// jtkcpu_opfetch : big-endian 8/16-bit memory operand fetch for the ALU | rev 1.0
// ============================================================================
`default_nettype none

module jtkcpu_opfetch
  import jtkcpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                start,
  input  logic                len16,
  input  logic                sext,
  input  logic [OPND_W16-1:0] addr,
  input  logic                hold,
  input  logic [OPND_W8-1:0]  mem_din,
  input  logic                bus_ok,
  output logic [OPND_W16-1:0] mem_addr,
  output logic                mem_rd,
  output logic [OPND_W16-1:0] opnd1,
  output logic                valid,
  output logic                busy
);

  fetch_state_t          state;
  logic                  r_len16;
  logic                  r_sext;
  logic [OPND_W16-1:0]   r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_len16  <= 1'b0;
      r_sext   <= 1'b0;
      r_addr   <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      opnd1    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else if (cen) begin
      case (state)
        IDLE: begin
          if (start) begin
            r_len16  <= len16;
            r_sext   <= sext;
            r_addr   <= addr;
            mem_addr <= addr;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= len16 ? RD_HI : RD_LO;
          end
        end
        RD_HI: begin
          if (bus_ok) begin
            opnd1[15:8] <= mem_din;
            // Low byte sits at the next address; the 16-bit add wraps FFFF to 0000.
            mem_addr    <= 16'(r_addr + 16'd1);
            state       <= RD_LO;
          end
        end
        RD_LO: begin
          if (bus_ok) begin
            opnd1[7:0] <= mem_din;
            if (!r_len16)
              opnd1[15:8] <= r_sext ? {8{mem_din[7]}} : 8'h00;
            mem_rd <= 1'b0;
            valid  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!hold) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/jtkcpu_opfetch.md
# jtkcpu_opfetch

Operand fetch stage upstream of the KCPU ALU. It reads an 8-bit or 16-bit memory operand over the CPU's byte-wide bus, big-endian (high byte at the lower address), and presents it as the 16-bit `opnd1` memory operand the ALU consumes for `_IDX` and memory opcodes. It sequences the bus reads, waits on memory readiness, and holds the result until the ALU side releases it.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `cen`  in  1  clock enable; all state advances only on `clk` edges with `cen`=1
- `start`  in  1  request a fetch; sampled only in IDLE
- `len16`  in  1  1 = two-byte operand, 0 = one byte; captured with `start`
- `sext`  in  1  8-bit fetch only: 1 = sign-extend the byte to 16 bits, 0 = zero-extend; captured with `start`
- `addr`  in  16  operand effective address; captured with `start`
- `hold`  in  1  consumer stall (ALU `busy`); keeps `valid`/`opnd1` asserted
- `mem_din`  in  8  memory read data
- `bus_ok`  in  1  memory ready; read data is valid when high
- `mem_addr`  out  16  bus address
- `mem_rd`  out  1  bus read strobe
- `opnd1`  out  16  fetched operand
- `valid`  out  1  `opnd1` is complete
- `busy`  out  1  fetch in progress (any state except IDLE)

## Operation
- States: IDLE, RD_HI, RD_LO, DONE. All outputs are registered.
- IDLE, `start`=1: latch `len16`, `sext`, `addr`; set `mem_addr`=`addr`, `mem_rd`=1.
  - If `len16`=1, go to RD_HI; otherwise go to RD_LO (single byte read at `addr`).
- RD_HI: on a `cen` edge with `bus_ok`=1:
  - `opnd1[15:8]` ← `mem_din`
  - `mem_addr` ← `addr`+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000
  - go to RD_LO
- RD_LO: on a `cen` edge with `bus_ok`=1:
  - `opnd1[7:0]` ← `mem_din`
  - for 8-bit fetches, `opnd1[15:8]` ← `sext` ? {8{`mem_din[7]`}} : 8'h00
  - `mem_rd` ← 0, `valid` ← 1, go to DONE
- Memory wait: while `bus_ok`=0 in RD_HI or RD_LO, `mem_addr` and `mem_rd` stay stable and no data is captured. The wait is unbounded.
- DONE: on a `cen` edge with `hold`=0, `valid` ← 0 and go to IDLE. With `hold`=1, stay in DONE with `valid`=1.
- `opnd1` keeps its last value after leaving DONE and changes only on the next capture.
- `start` outside IDLE is ignored; the request is not queued.
- `cen`=0 freezes all state, including in the middle of a wait.
- Reset values (async, `rst_n`=0):
  - state IDLE
  - `mem_addr`=0, `mem_rd`=0, `opnd1`=0, `valid`=0, `busy`=0
- Reset asserted in the middle of a fetch abandons it immediately. `mem_rd` drops in the same cycle, without waiting for a clock edge.

## Timing
- Latencies below assume `cen`=1 every cycle and `bus_ok`=1.
- 8-bit fetch: `start` at edge E0 → `mem_rd`=1 after E0 → byte captured at E1 → `valid`=1 after E1 → `valid`=0 after E2 if `hold`=0.
- 16-bit fetch: `start` at E0; high byte captured at E1; low byte captured at E2; `valid` high after E2.
- Each cycle of `bus_ok`=0 adds one `cen` edge of latency.
- Earliest next `start` is accepted at the edge after returning to IDLE, giving a minimum issue interval of 3 `cen` edges (8-bit) or 4 (16-bit).
- `busy` is 1 from the edge after `start` until the edge that enters IDLE.

## Structure
- Shared package `jtkcpu_pkg` holds:
  - the state encoding localparams (2-bit: IDLE=0, RD_HI=1, RD_LO=2, DONE=3)
  - the operand width constants used by the ALU's 8/16-bit selection
- Single module; no sub-module is warranted.
- One `always` block for the FSM and registers; the address increment is inline.

## Test plan
- 8-bit zero-extend: memory[16'h1234]=8'hA5, `start` with `len16`=0, `sext`=0 → one read at 16'h1234, then `opnd1`=16'h00A5 with `valid` for 1 cycle.
- 8-bit sign-extend: same byte with `sext`=1 → `opnd1`=16'hFFA5.
- 16-bit with wrap: `addr`=16'hFFFF, memory[FFFF]=8'h12, memory[0000]=8'h34 → reads at 16'hFFFF then 16'h0000; `opnd1`=16'h1234.
- Bus wait and `cen` gating: hold `bus_ok`=0 for 3 cycles during RD_LO and toggle `cen` → `mem_addr`/`mem_rd` stay stable throughout; `valid` is delayed by exactly the stalled `cen` edges.
- Hold and ignored start: in DONE with `hold`=1 for 4 cycles, pulse `start` → `valid` stays high, the pulse is ignored, and no bus read occurs; `valid` drops after `hold` falls.
- Reset mid-fetch: assert `rst_n`=0 during RD_HI → `mem_rd`, `busy`, `valid` go to 0 asynchronously and `opnd1`=0; after release, a fresh fetch completes normally.
